// File: rtl/cache_rd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cache_rd_arbiter_pkg
//   Shared definitions for the cache refill read-port arbiter.
//   - arb_state_e : one-hot FSM encodings ARB_IDLE / ARB_REQ / ARB_WAIT
//   - OWN_IC/OWN_DC : owner encodings (0 = icache, 1 = dcache)
//   - ARB_ADDR_W / ARB_LINE_W : default address and line widths
//   Optional feature macro used by the importing files: CACHE_ARB_RR_EN
// ---------------------------------------------------------------------------
package cache_rd_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_LINE_W = 128;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'b001,
    ARB_REQ  = 3'b010,
    ARB_WAIT = 3'b100
  } arb_state_e;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

endpackage

// File: rtl/cache_arb_pick.sv
// ---------------------------------------------------------------------------
// cache_arb_pick
//   Combinational winner selection between the icache and dcache requests.
//   Build option: CACHE_ARB_RR_EN selects round-robin, otherwise the dcache
//   has fixed priority.
//   Ports:
//     ic_req  in  icache request
//     dc_req  in  dcache request
//     rr_last in  last granted requester (only meaningful in round-robin)
//     winner  out OWN_IC / OWN_DC; only meaningful when a request is present
// ---------------------------------------------------------------------------
module cache_arb_pick
  import cache_rd_arbiter_pkg::*;
(
  input  logic ic_req,
  input  logic dc_req,
  input  logic rr_last,
  output logic winner
);

`ifdef CACHE_ARB_RR_EN
  // On a conflict the requester that was not served last time wins; a lone
  // requester always wins regardless of history.
  always_comb begin
    winner = OWN_IC;
    if (ic_req && dc_req) begin
      winner = (rr_last == OWN_DC) ? OWN_IC : OWN_DC;
    end else if (dc_req) begin
      winner = OWN_DC;
    end
  end
`else
  // Fixed priority: the dcache wins whenever it asks. The icache request and
  // the history input do not influence the result in this build.
  assign winner = dc_req ? OWN_DC : OWN_IC;

  logic unused_pick_inputs;
  assign unused_pick_inputs = ic_req ^ rr_last;
`endif

endmodule

// File: rtl/cache_rd_arbiter.sv
// ---------------------------------------------------------------------------
// cache_rd_arbiter
//   Shares the single cache-refill read port of the AXI bridge between the
//   instruction cache and the data cache. One transaction is outstanding
//   downstream at a time; the single-beat return is routed to its owner.
//   Build option: CACHE_ARB_RR_EN enables round-robin arbitration (adds the
//   rr_last history register); default is fixed dcache priority.
//   Ports:
//     clk, reset                 clock, asynchronous active-high reset
//     ic_rd_req/type/addr        icache request (held until ic_rd_rdy)
//     ic_rd_rdy                  icache request accepted this cycle
//     ic_ret_valid/ic_ret_data   icache return beat
//     dc_*                       same set for the dcache
//     mem_rd_req/type/addr       request to the bridge (type/addr latched)
//     mem_rd_rdy                 bridge accepts the request
//     mem_ret_valid/data         single-cycle whole-line return
// ---------------------------------------------------------------------------
module cache_rd_arbiter
  import cache_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              ic_rd_req,
  input  logic              ic_rd_type,
  input  logic [ADDR_W-1:0] ic_rd_addr,
  output logic              ic_rd_rdy,
  output logic              ic_ret_valid,
  output logic [LINE_W-1:0] ic_ret_data,

  input  logic              dc_rd_req,
  input  logic              dc_rd_type,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  output logic              dc_rd_rdy,
  output logic              dc_ret_valid,
  output logic [LINE_W-1:0] dc_ret_data,

  output logic              mem_rd_req,
  output logic              mem_rd_type,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_rdy,
  input  logic              mem_ret_valid,
  input  logic [LINE_W-1:0] mem_ret_data
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              type_q,  type_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;

  logic winner;
  logic rr_last;
  logic grant;   // IDLE cycle in which a request is taken

  assign grant = (state_q == ARB_IDLE) && (ic_rd_req || dc_rd_req);

`ifdef CACHE_ARB_RR_EN
  logic rr_last_q, rr_last_d;

  always_comb begin
    rr_last_d = rr_last_q;
    if (grant) begin
      rr_last_d = winner;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last_q <= OWN_IC;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  assign rr_last = rr_last_q;
`else
  assign rr_last = OWN_IC;
`endif

  cache_arb_pick u_pick (
    .ic_req  (ic_rd_req),
    .dc_req  (dc_rd_req),
    .rr_last (rr_last),
    .winner  (winner)
  );

  // Next-state and output decode. Outputs are purely a function of the
  // current state and the bridge handshakes, so rd_rdy and ret_valid follow
  // mem_rd_rdy / mem_ret_valid with zero cycles of latency.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    type_d       = type_q;
    addr_d       = addr_q;

    mem_rd_req   = 1'b0;
    ic_rd_rdy    = 1'b0;
    dc_rd_rdy    = 1'b0;
    ic_ret_valid = 1'b0;
    dc_ret_valid = 1'b0;
    ic_ret_data  = '0;
    dc_ret_data  = '0;

    case (state_q)
      ARB_IDLE: begin
        if (grant) begin
          owner_d = winner;
          type_d  = (winner == OWN_DC) ? dc_rd_type : ic_rd_type;
          addr_d  = (winner == OWN_DC) ? dc_rd_addr : ic_rd_addr;
          state_d = ARB_REQ;
        end
      end

      ARB_REQ: begin
        // The latched request is issued even if the cache has since dropped
        // its rd_req; stray mem_ret_valid here is ignored.
        mem_rd_req = 1'b1;
        if (mem_rd_rdy) begin
          ic_rd_rdy = (owner_q == OWN_IC);
          dc_rd_rdy = (owner_q == OWN_DC);
          state_d   = ARB_WAIT;
        end
      end

      ARB_WAIT: begin
        // Data is broadcast to both caches; only the owner sees valid.
        ic_ret_data  = mem_ret_data;
        dc_ret_data  = mem_ret_data;
        ic_ret_valid = mem_ret_valid && (owner_q == OWN_IC);
        dc_ret_valid = mem_ret_valid && (owner_q == OWN_DC);
        if (mem_ret_valid) begin
          state_d = ARB_IDLE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IC;
      type_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
    end
  end

  assign mem_rd_type = type_q;
  assign mem_rd_addr = addr_q;

endmodule
